// File: rtl/vector_clkgen.sv
// vector_clkgen: Vector-06C bus clock enables, PSG/PIT clocks and CPU wait states on clk_sys; optional CPU pause input via CLKGEN_PAUSE_EN
module vector_clkgen #(
    parameter  int DIV_W      = 7,
    parameter  int BASE_LOG2  = 5,
    parameter  int NUM_SPEEDS = 4,
    parameter  int WAIT_SLOT  = 4,
    parameter  int PSG_INC    = 1195,
    parameter  int PIT_BIT    = 5,
    localparam int SW         = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic [SW-1:0] speed,
    input  logic          wait_en,
    input  logic          cpu_sync,
    input  logic          mreq,
`ifdef CLKGEN_PAUSE_EN
    input  logic          pause,
`endif
    output logic          ce_f1,
    output logic          ce_f2,
    output logic          ce_12mp,
    output logic          ce_12mn,
    output logic          ce_psg,
    output logic          clk_pit,
    output logic          cpu_ready,
    output logic [SW-1:0] speed_q
);
    localparam logic [DIV_W-BASE_LOG2:0] WAIT_V   = WAIT_SLOT[DIV_W-BASE_LOG2:0];
    localparam logic [16:0]              PSG_STEP = {1'b0, PSG_INC[15:0]};

    logic [DIV_W-1:0] div_q, div_d;
    logic [SW-1:0]    speed_d;
    logic [15:0]      psg_acc_q, psg_acc_d;
    logic [16:0]      psg_sum;
    logic [DIV_W-1:0] half_bit, phase_mask;
    logic             run;
    logic             wait_q, wait_d;
    logic             release_hit, assert_hit;
    logic             ce_f1_q, ce_f1_d, ce_f2_q, ce_f2_d;
    logic             ce_12mp_q, ce_12mp_d, ce_12mn_q, ce_12mn_d;
    logic             ce_psg_q, ce_psg_d, clk_pit_q, clk_pit_d;
    logic             cpu_ready_q, cpu_ready_d;

`ifdef CLKGEN_PAUSE_EN
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif

    // Next-state: master divider, frame-aligned speed latch, phase decode, PSG accumulator and wait tracking
    always_comb begin
        div_d       = div_q + DIV_W'(1);
        speed_d     = (&div_q) ? ((int'(speed) < NUM_SPEEDS) ? speed : SW'(NUM_SPEEDS - 1)) : speed_q;
        half_bit    = DIV_W'(1) << (BASE_LOG2 - 1 - int'(speed_q));
        phase_mask  = half_bit | (half_bit - DIV_W'(1));
        ce_f1_d     = run && ((div_q & phase_mask) == '0);
        ce_f2_d     = run && ((div_q & phase_mask) == half_bit);
        ce_12mp_d   = div_q[2:0] == 3'd0;
        ce_12mn_d   = div_q[2:0] == 3'd4;
        psg_sum     = {1'b0, psg_acc_q} + PSG_STEP;
        psg_acc_d   = psg_sum[15:0];
        ce_psg_d    = psg_sum[16];
        clk_pit_d   = div_q[PIT_BIT];
        release_hit = div_q[DIV_W-1:BASE_LOG2-1] == WAIT_V;
        assert_hit  = (div_q[BASE_LOG2-1:2] == '0) && cpu_sync && mreq;
        wait_d      = ((speed_q != '0) || !wait_en || release_hit) ? 1'b0 : (assert_hit ? 1'b1 : wait_q);
        cpu_ready_d = run && !wait_d;
    end

    // State registers; every output is a flop so reset clears them asynchronously
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            speed_q     <= '0;
            psg_acc_q   <= '0;
            wait_q      <= 1'b0;
            ce_f1_q     <= 1'b0;
            ce_f2_q     <= 1'b0;
            ce_12mp_q   <= 1'b0;
            ce_12mn_q   <= 1'b0;
            ce_psg_q    <= 1'b0;
            clk_pit_q   <= 1'b0;
            cpu_ready_q <= 1'b1;
        end else begin
            div_q       <= div_d;
            speed_q     <= speed_d;
            psg_acc_q   <= psg_acc_d;
            wait_q      <= wait_d;
            ce_f1_q     <= ce_f1_d;
            ce_f2_q     <= ce_f2_d;
            ce_12mp_q   <= ce_12mp_d;
            ce_12mn_q   <= ce_12mn_d;
            ce_psg_q    <= ce_psg_d;
            clk_pit_q   <= clk_pit_d;
            cpu_ready_q <= cpu_ready_d;
        end
    end

    assign ce_f1     = ce_f1_q;
    assign ce_f2     = ce_f2_q;
    assign ce_12mp   = ce_12mp_q;
    assign ce_12mn   = ce_12mn_q;
    assign ce_psg    = ce_psg_q;
    assign clk_pit   = clk_pit_q;
    assign cpu_ready = cpu_ready_q;
endmodule

// File: tb/tb_vector_clkgen.sv
// tb_vector_clkgen: randomized bench for vector_clkgen against an arithmetic reference model
module tb_vector_clkgen;
    logic       clk_sys = 1'b0;
    logic       reset   = 1'b0;
    logic [1:0] speed   = 2'd0;
    logic       wait_en = 1'b0;
    logic       cpu_sync = 1'b0;
    logic       mreq    = 1'b0;
    logic       pz_in;
    logic       ce_f1, ce_f2, ce_12mp, ce_12mn, ce_psg, clk_pit, cpu_ready;
    logic [1:0] speed_q;
    int         n_chk = 0, n_fail = 0;

`ifdef CLKGEN_PAUSE_EN
    logic pause = 1'b0;
    assign pz_in = pause;
`else
    assign pz_in = 1'b0;
`endif

    vector_clkgen dut (
        .clk_sys(clk_sys), .reset(reset), .speed(speed), .wait_en(wait_en),
        .cpu_sync(cpu_sync), .mreq(mreq),
`ifdef CLKGEN_PAUSE_EN
        .pause(pause),
`endif
        .ce_f1(ce_f1), .ce_f2(ce_f2), .ce_12mp(ce_12mp), .ce_12mn(ce_12mn),
        .ce_psg(ce_psg), .clk_pit(clk_pit), .cpu_ready(cpu_ready), .speed_q(speed_q)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: period P = 32 >> speed, phases from div mod P, PSG from a modulo-65536 accumulator
    int m_div, m_spd, m_acc;
    bit m_wait, m_f1, m_f2, m_mp, m_mn, m_psg, m_pit, m_pz;
    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m_div <= 0; m_spd <= 0; m_acc <= 0; m_wait <= 0; m_pz <= 0;
            m_f1 <= 0; m_f2 <= 0; m_mp <= 0; m_mn <= 0; m_psg <= 0; m_pit <= 0;
        end else begin
            m_div <= (m_div + 1) % 128;
            if (m_div == 127) m_spd <= int'(speed);
            m_f1  <= ((m_div % (32 >> m_spd)) == 0) && !pz_in;
            m_f2  <= ((m_div % (32 >> m_spd)) == (16 >> m_spd)) && !pz_in;
            m_mp  <= (m_div % 8) == 0;
            m_mn  <= (m_div % 8) == 4;
            m_acc <= (m_acc + 1195) % 65536;
            m_psg <= (m_acc + 1195) >= 65536;
            m_pit <= ((m_div / 32) % 2) == 1;
            m_pz  <= pz_in;
            if (m_spd != 0 || !wait_en || (m_div / 16) == 4) m_wait <= 0;
            else if ((m_div % 32) < 4 && cpu_sync && mreq) m_wait <= 1;
        end
    end

    // Cycle-by-cycle comparison against the model, sampled on the falling edge
    always @(negedge clk_sys) begin
        if (!reset) begin
            chk("ce_f1", ce_f1, m_f1);
            chk("ce_f2", ce_f2, m_f2);
            chk("ce_12mp", ce_12mp, m_mp);
            chk("ce_12mn", ce_12mn, m_mn);
            chk("ce_psg", ce_psg, m_psg);
            chk("clk_pit", clk_pit, m_pit);
            chk("cpu_ready", cpu_ready, !(m_wait || m_pz));
            chk("speed_q", speed_q, m_spd);
        end
    end

    task automatic wait_div(input int v);
        int n = 0;
        while (m_div != v && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        chk("wait_div_timeout", m_div, v);
    endtask

    task automatic sync_pulse();
        cpu_sync = 1'b1;
        @(negedge clk_sys);
        cpu_sync = 1'b0;
    endtask

    int psg_cnt, mp_cnt, mn_cnt, pit_tog, f_cnt, rdy_cnt, n;
    logic pit_prev;

    initial begin
        #1 reset = 1'b1;
        #20;
        @(negedge clk_sys);
        chk("rst_ready", cpu_ready, 1);
        chk("rst_f1", ce_f1, 0);
        reset = 1'b0;
        // reset release: ce_f1 at div=1, ce_f2 16 later, ce_f1 again 32 later
        @(negedge clk_sys);
        chk("first_f1", ce_f1, 1);
        repeat (16) @(negedge clk_sys);
        chk("first_f2", ce_f2, 1);
        repeat (16) @(negedge clk_sys);
        chk("second_f1", ce_f1, 1);
        chk("ready_idle", cpu_ready, 1);
        // mid-frame speed change applies only after the wrap
        wait_div(37);
        speed = 2'd3;
        wait_div(127);
        chk("speed_hold", speed_q, 0);
        @(negedge clk_sys);
        chk("speed_new", speed_q, 3);
        @(negedge clk_sys);
        chk("fast_f1", ce_f1, 1);
        repeat (2) @(negedge clk_sys);
        chk("fast_f2", ce_f2, 1);
        repeat (2) @(negedge clk_sys);
        chk("fast_f1b", ce_f1, 1);
        // wait state in slowest mode
        speed = 2'd0;
        wait_div(127);
        @(negedge clk_sys);
        wait_en = 1'b1;
        mreq = 1'b1;
        wait_div(2);
        sync_pulse();
        chk("wait_on", cpu_ready, 0);
        wait_div(64);
        chk("wait_hold", cpu_ready, 0);
        @(negedge clk_sys);
        chk("wait_release", cpu_ready, 1);
        mreq = 1'b0;
        wait_div(2);
        sync_pulse();
        chk("no_wait_io", cpu_ready, 1);
        // async reset while waiting with ce_f2 due
        mreq = 1'b1;
        wait_div(2);
        sync_pulse();
        wait_div(16);
        chk("pre_rst_ready", cpu_ready, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_f1", ce_f1, 0);
        chk("arst_f2", ce_f2, 0);
        chk("arst_mp", ce_12mp, 0);
        chk("arst_mn", ce_12mn, 0);
        chk("arst_psg", ce_psg, 0);
        chk("arst_pit", clk_pit, 0);
        chk("arst_ready", cpu_ready, 1);
        chk("arst_speed", speed_q, 0);
        @(negedge clk_sys);
        reset = 1'b0;
        wait_en = 1'b0;
        mreq = 1'b0;
        @(negedge clk_sys);
        chk("rerst_f1", ce_f1, 1);
        repeat (16) @(negedge clk_sys);
        chk("rerst_f2", ce_f2, 1);
        // randomized traffic, continuously checked by the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_sys);
            if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) wait_en = ~wait_en;
            mreq = 1'($urandom);
            cpu_sync = ($urandom_range(0, 5) == 0);
        end
        cpu_sync = 1'b0;
        // long-run rates over exactly 65536 cycles
        psg_cnt = 0; mp_cnt = 0; mn_cnt = 0; pit_tog = 0;
        pit_prev = clk_pit;
        repeat (65536) begin
            @(negedge clk_sys);
            psg_cnt += int'(ce_psg);
            mp_cnt += int'(ce_12mp);
            mn_cnt += int'(ce_12mn);
            if (clk_pit != pit_prev) pit_tog++;
            pit_prev = clk_pit;
        end
        chk("psg_count", psg_cnt, 1195);
        chk("mp_count", mp_cnt, 8192);
        chk("mn_count", mn_cnt, 8192);
        chk("pit_toggles", pit_tog, 2048);
`ifdef CLKGEN_PAUSE_EN
        speed = 2'd1;
        wait_en = 1'b0;
        wait_div(127);
        @(negedge clk_sys);
        pause = 1'b1;
        f_cnt = 0; rdy_cnt = 0; mp_cnt = 0;
        repeat (100) begin
            @(negedge clk_sys);
            f_cnt += int'(ce_f1) + int'(ce_f2);
            rdy_cnt += int'(cpu_ready);
            mp_cnt += int'(ce_12mp);
        end
        pause = 1'b0;
        chk("pause_enables", f_cnt, 0);
        chk("pause_ready", rdy_cnt, 0);
        chk("pause_mp_runs", mp_cnt >= 12, 1);
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!ce_f1 && n < 40);
        chk("resume_align", (m_div + 127) % 16, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vector_clkgen.md
Name: vector_clkgen

Overview:
- Parametrised clock-enable and wait-state generator for the Vector-06C system bus, running entirely on clk_sys (96 MHz).
- Produces:
  - CPU two-phase enables (ce_f1/ce_f2) for N selectable speeds, switched glitch-free only at frame boundaries.
  - Video-phase enables (ce_12mp/ce_12mn).
  - A fractional-divided PSG enable.
  - The PIT timer clock.
  - The cpu_ready wait-state signal that steals memory slots from the CPU in the slowest mode.
- Replaces the fixed 2-speed divider in the top level.

Parameters:
- DIV_W, 7, master counter width; must exceed BASE_LOG2.
- BASE_LOG2, 5, log2 of the slowest CPU period in clk_sys ticks (32 = 3 MHz).
- NUM_SPEEDS, 4, number of speed modes; requires BASE_LOG2-(NUM_SPEEDS-1) >= 1.
- WAIT_SLOT, 4, value of div[DIV_W-1:BASE_LOG2-1] at which a pending wait is released.
- PSG_INC, 1195, 16-bit phase increment per clk_sys; ce_psg rate = 96 MHz * PSG_INC / 65536 ≈ 1.75 MHz.
- PIT_BIT, 5, div bit driven out as clk_pit (1.5 MHz).

Ports:
- clk_sys  in  1  system clock, 96 MHz.
- reset  in  1  asynchronous, active-high.
- speed  in  $clog2(NUM_SPEEDS)  requested speed; 0 = slowest; each step halves the period.
- wait_en  in  1  enable memory wait states; effective in speed 0 only.
- cpu_sync  in  1  CPU SYNC, start of machine cycle.
- mreq  in  1  decoded memory-cycle qualifier from the status word.
- ce_f1  out  1  CPU phase-1 enable, one clk_sys wide.
- ce_f2  out  1  CPU phase-2 enable, one clk_sys wide.
- ce_12mp  out  1  12 MHz enable, phase 0.
- ce_12mn  out  1  12 MHz enable, phase 4.
- ce_psg  out  1  PSG clock enable, one clk_sys wide.
- clk_pit  out  1  PIT timer clock, 50% duty.
- cpu_ready  out  1  CPU READY; 0 inserts a wait state.
- speed_q  out  $clog2(NUM_SPEEDS)  currently effective speed.

Behaviour:
- Reset (async):
  - div=0, psg_acc=0, speed_q=0.
  - ce_* = 0, clk_pit = 0, cpu_ready = 1.
- Counter and speed latch:
  - div increments by 1 every clk_sys and wraps modulo 2^DIV_W.
  - speed_q <= speed only in the cycle where div is all-ones. The new speed therefore takes effect from div=0, and a phase never truncates mid-period.
  - Changes to speed at any other time are ignored until the next wrap.
- CPU phase enables:
  - L = BASE_LOG2 - speed_q; P = 2^L.
  - All outputs are registered from the current div, giving 1-cycle latency.
  - ce_f1 <= (div[L-1] == 0) && (div[L-2:0] == 0).
  - ce_f2 <= (div[L-1] == 1) && (div[L-2:0] == 0).
  - Result: ce_f1 pulses every P cycles, and ce_f2 pulses exactly P/2 cycles after each ce_f1.
  - Special case L = 1: ce_f1 on even div, ce_f2 on odd div.
- Video enables:
  - ce_12mp <= (div[2:0] == 0).
  - ce_12mn <= (div[2:0] == 4).
  - Both are independent of speed.
- PSG enable:
  - {carry, psg_acc} <= psg_acc + PSG_INC each cycle.
  - ce_psg <= carry.
  - Long-run rate is exact; jitter is at most 1 clk_sys.
- PIT clock: clk_pit <= div[PIT_BIT].
- Wait states:
  - If speed_q != 0 or wait_en = 0: cpu_ready <= 1.
  - Otherwise, release: cpu_ready <= 1 when div[DIV_W-1:BASE_LOG2-1] == WAIT_SLOT.
  - Otherwise, assert: cpu_ready <= 0 when div[BASE_LOG2-1:2] == 0 && cpu_sync && mreq.
  - If release and assert hit in the same cycle, release wins.
  - A wait therefore spans from the 4-tick window at the start of a CPU period to the release slot.
  - Non-memory cycles (mreq = 0) never wait.
- Speed transitions: a speed change out of mode 0 forces cpu_ready = 1 on the next cycle, so a pending wait is dropped.
- Reset mid-operation: all state returns to reset values immediately. After release, the first ce_f1 occurs one cycle after div = 0, i.e. in the cycle div = 1.

Optional Feature:
- Macro: CLKGEN_PAUSE_EN.
- When defined:
  - Extra input port pause (1 bit) is present.
  - While pause = 1, ce_f1 and ce_f2 are forced to 0 and cpu_ready to 0.
  - div, ce_12mp/ce_12mn, ce_psg and clk_pit keep running.
  - On pause deassert, CPU enables resume at the next natural phase boundary; no partial pulse.
- When undefined: the port does not exist and behaviour is as above.

Test Plan:
- Reset release, speed=0, wait_en=0 → ce_f1 first high in the cycle div=1, then every 32 cycles; ce_f2 16 cycles after each ce_f1; cpu_ready constant 1.
- speed changed 0→3 mid-frame (div=37) → still period 32 until div wraps at 127; from div=0 the period is 4, with ce_f2 2 cycles after ce_f1; speed_q updates the cycle after div=127.
- speed=0, wait_en=1, mreq=1, cpu_sync pulsed with div=2 → cpu_ready=0 from the next cycle until the cycle after div[6:4]==4 (div=64); back to 1 at div=65; mreq=0 → no wait.
- 65536 clk_sys cycles → exactly 1195 ce_psg pulses; ce_12mp/ce_12mn each 8192 pulses, 4 cycles apart; clk_pit toggles every 32 cycles.
- Assert reset while cpu_ready=0 and ce_f2 is due → all enables 0 and cpu_ready 1 in the same cycle (async); sequence restarts per scenario 1.
- With CLKGEN_PAUSE_EN defined, pause high for 100 cycles at speed 1 → zero ce_f1/ce_f2 and cpu_ready=0 throughout; ce_12mp continues; after release, the first ce_f1 aligns to div[3:0]==0 (div low bits).
